mips_debug_ctrl: RTL

- CPU-side responder for the board debug interface (debug_en switch, debug_step button, debug_addr/debug_data readback) that the top-level mips instantiates.
- Converts the asynchronous, bouncy debug_step button into exact single-cycle CPU advance pulses while halted, and free-runs the CPU otherwise.
- Serves register-file and status readback over debug_addr/debug_data.
- Sits between the top-level ports and the datapath; the datapath gates all state updates with cpu_en.

---
 rtl/mips_debug_pkg.sv | 24 ++
 rtl/debug_debounce.sv | 66 ++++++
 rtl/mips_debug_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_debug_pkg.sv
// Shared encodings for the CPU debug controller: FSM state values and the
// fixed readback addresses above the register-file window.
package mips_debug_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } dbg_state_e;

  localparam logic [6:0] DBG_ADDR_PC   = 7'd32;
  localparam logic [6:0] DBG_ADDR_INST = 7'd33;
  localparam logic [6:0] DBG_ADDR_CYC  = 7'd34;
  localparam logic [6:0] DBG_ADDR_STEP = 7'd35;
  localparam logic [6:0] DBG_ADDR_STAT = 7'd36;

  // Status word layout: {28'b0, synced debug_en, filtered step, state}
  function automatic logic [31:0] status_word(input logic en_synced,
                                              input logic step_level,
                                              input dbg_state_e state);
    return {28'b0, en_synced, step_level, state};
  endfunction

endpackage

// File: rtl/debug_debounce.sv
// Synchroniser, debounce filter and rising-edge detector for the step button.
// The step pulse is registered after the filtered level so it is one cycle wide.
module debug_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   level_prev_reg;
  logic                   pulse_reg;
  logic                   synced;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = din;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg       <= '0;
      cnt_reg        <= '0;
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
      pulse_reg      <= 1'b0;
    end else begin
      sync_reg       <= sync_next;
      level_prev_reg <= level_reg;
      pulse_reg      <= level_reg & ~level_prev_reg;
      // Any cycle of agreement restarts the stability count.
      if (synced != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= synced;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/mips_debug_ctrl.sv
// CPU-side debug responder: halt/run/single-step control of the datapath
// enable plus registered readback of register file, PC, instruction and counters.
module mips_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        debug_en,
  input  logic        debug_step,
  input  logic [6:0]  debug_addr,
  output logic [31:0] debug_data,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] dbg_pc,
  input  logic [31:0] dbg_inst,
  output logic        cpu_en
);

  logic [SYNC_STAGES-1:0] en_sync_reg;
  logic [SYNC_STAGES-1:0] en_sync_next;
  logic                   en_synced;
  logic                   step_level;
  logic                   step_req;
  dbg_state_e             state_reg;
  dbg_state_e             state_next;
  logic                   cpu_en_reg;
  logic [31:0]            cycle_cnt_reg;
  logic [31:0]            step_cnt_reg;
  logic [31:0]            debug_data_reg;
  logic [31:0]            rd_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_en_sync
      if (gi == 0) begin : g_first
        assign en_sync_next[gi] = debug_en;
      end else begin : g_rest
        assign en_sync_next[gi] = en_sync_reg[gi-1];
      end
    end
  endgenerate

  assign en_synced = en_sync_reg[SYNC_STAGES-1];

  debug_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step (
    .clk   (clk),
    .rst   (rst),
    .din   (debug_step),
    .level (step_level),
    .pulse (step_req)
  );

  // STEP never persists, so step requests arriving in RUN or STEP are dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HALT: begin
        if (!en_synced)    state_next = RUN;
        else if (step_req) state_next = STEP;
      end
      RUN:     if (en_synced) state_next = HALT;
      STEP:    state_next = en_synced ? HALT : RUN;
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    rd_next = '0;
    if (debug_addr[6:5] == 2'b00) begin
      rd_next = rf_data;
    end else begin
      case (debug_addr)
        DBG_ADDR_PC:   rd_next = dbg_pc;
        DBG_ADDR_INST: rd_next = dbg_inst;
        DBG_ADDR_CYC:  rd_next = cycle_cnt_reg;
        DBG_ADDR_STEP: rd_next = step_cnt_reg;
        DBG_ADDR_STAT: rd_next = status_word(en_synced, step_level, state_reg);
        default:       rd_next = '0;
      endcase
    end
  end

  // cpu_en is decoded from the next state so it is a clean flop output
  // aligned with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync_reg    <= '1;
      state_reg      <= HALT;
      cpu_en_reg     <= 1'b0;
      cycle_cnt_reg  <= '0;
      step_cnt_reg   <= '0;
      debug_data_reg <= '0;
    end else begin
      en_sync_reg    <= en_sync_next;
      state_reg      <= state_next;
      cpu_en_reg     <= (state_next != HALT);
      debug_data_reg <= rd_next;
      if (cpu_en_reg)
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (state_next == STEP && state_reg != STEP)
        step_cnt_reg <= step_cnt_reg + 32'd1;
    end
  end

  assign rf_addr    = debug_addr[4:0];
  assign debug_data = debug_data_reg;
  assign cpu_en     = cpu_en_reg;

endmodule
